// File: rtl/if_id_fetch_stage.sv
// ============================================================================
// Module      : if_id_fetch_stage
// Description : Instruction fetch stage with PC, imem request handshake and
//               IF/ID pipeline register. The optional stall counter output is
//               enabled by defining STALL_COUNTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write_enable,
    input  logic        if_id_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
`ifdef STALL_COUNTER_EN
    ,
    output logic [15:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] c_pc_step    = 32'd4;
    localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;
    localparam logic [31:0] c_reset_pc   = RESET_PC & c_align_mask;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_if_id_pc;
    logic [31:0] w_if_id_pc_next;
    logic [31:0] r_if_id_instr;
    logic [31:0] w_if_id_instr_next;
    logic        r_if_id_valid;
    logic        w_if_id_valid_next;
    logic [31:0] r_hold_buf;
    logic [31:0] w_hold_buf_next;

    logic        w_stall;
    logic [31:0] w_target_aligned;
    logic [31:0] w_pc_plus4;

    assign w_stall          = ~pc_write_enable | ~if_id_write;
    assign w_target_aligned = branch_target & c_align_mask;
    assign w_pc_plus4       = r_pc + c_pc_step;

    // ------------------------------------------------------------------
    // Next-state and datapath selection
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_if_id_pc_next    = r_if_id_pc;
        w_if_id_instr_next = r_if_id_instr;
        w_if_id_valid_next = r_if_id_valid;
        w_hold_buf_next    = r_hold_buf;

        case (r_state)
            IDLE: begin
                w_state_next = FETCH;
            end

            FETCH: begin
                if (imem_valid && !w_stall) begin
                    w_if_id_pc_next    = r_pc;
                    w_if_id_instr_next = imem_rdata;
                    w_if_id_valid_next = 1'b1;
                    w_pc_next          = w_pc_plus4;
                end else if (imem_valid) begin
                    w_hold_buf_next = imem_rdata;
                    w_state_next    = HOLD;
                end else if (!w_stall) begin
                    w_if_id_pc_next    = r_pc;
                    w_if_id_instr_next = NOP_INSTR;
                    w_if_id_valid_next = 1'b0;
                end
            end

            HOLD: begin
                if (!w_stall) begin
                    w_if_id_pc_next    = r_pc;
                    w_if_id_instr_next = r_hold_buf;
                    w_if_id_valid_next = 1'b1;
                    w_pc_next          = w_pc_plus4;
                    w_state_next       = FETCH;
                end
            end

            DRAIN: begin
                // The response to the abandoned request is dropped here.
                if (imem_valid) begin
                    w_state_next = FETCH;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase

        // A redirect overrides stall and any response in every state.
        if (branch_taken) begin
            w_pc_next          = w_target_aligned;
            w_if_id_pc_next    = w_target_aligned;
            w_if_id_instr_next = NOP_INSTR;
            w_if_id_valid_next = 1'b0;
            w_hold_buf_next    = '0;
            if ((r_state == FETCH || r_state == DRAIN) && !imem_valid) begin
                w_state_next = DRAIN;
            end else begin
                w_state_next = FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pc          <= c_reset_pc;
            r_if_id_pc    <= '0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
            r_hold_buf    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_if_id_pc    <= w_if_id_pc_next;
            r_if_id_instr <= w_if_id_instr_next;
            r_if_id_valid <= w_if_id_valid_next;
            r_hold_buf    <= w_hold_buf_next;
        end
    end

    // A request is in flight for every cycle spent in FETCH.
    assign imem_req    = (r_state == FETCH);
    assign imem_addr   = r_pc;
    assign pc_out      = r_pc;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_valid = r_if_id_valid;

`ifdef STALL_COUNTER_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && !branch_taken && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule

`default_nettype wire
